// File: rtl/wall_generator_pkg.sv
// Shared game definitions: position type, playfield limits, wall slot count
// and the wall generator state encoding.
package wall_generator_pkg;

    typedef logic [7:0] pos_t;

    localparam int   GRID_MIN  = 1;
    localparam int   GRID_MAX  = 14;
    localparam int   MAX_WALLS = 25;
    localparam pos_t EMPTY_POS = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GEN,
        ST_DONE
    } wall_gen_state_t;

    // Absolute difference of two 4-bit coordinates without wrap-around.
    function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/wall_generator_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (period 255).
module wall_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: shift left, feedback from taps 8,6,5,4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // State register; advances every cycle regardless of the consumer's state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/wall_generator.sv
// Wall generator: on a start pulse, fills up to MAX_WALLS unique legal wall
// cells drawn from a free-running LFSR, avoiding the border ring, the head's
// 3x3 neighbourhood, the apple and walls already placed.
module wall_generator #(
    parameter int         MAX_WALLS = 25,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter logic [7:0] EMPTY_POS = 8'h00
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          gen_start,
    input  logic [4:0]                    num_walls,
    input  logic [7:0]                    head_pos,
    input  logic [7:0]                    apple_pos,
    output logic [MAX_WALLS-1:0][7:0]     walls,
    output logic [4:0]                    wall_count,
    output logic                          busy,
    output logic                          done
);
    import wall_generator_pkg::*;

    localparam logic [4:0] MAX_W5 = 5'(MAX_WALLS);

    wall_gen_state_t            state_q, state_d;
    logic [MAX_WALLS-1:0][7:0]  walls_q, walls_d;
    logic [4:0]                 wall_count_q, wall_count_d;
    logic [4:0]                 target_q, target_d;
    logic [7:0]                 head_q, head_d;
    logic [7:0]                 apple_q, apple_d;

    logic [7:0]                 cand;
    logic [3:0]                 cx, cy;
    logic [MAX_WALLS-1:0]       dup_hit;
    logic                       on_border;
    logic                       near_head;
    logic                       accept;
    logic [4:0]                 count_inc;

    wall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .nrst  (nrst),
        .value (cand)
    );

    assign cx = cand[7:4];
    assign cy = cand[3:0];

    // Parallel compare of the candidate against every filled slot.
    for (genvar gi = 0; gi < MAX_WALLS; gi++) begin : g_dup
        assign dup_hit[gi] = (5'(gi) < wall_count_q) && (walls_q[gi] == cand);
    end

    // Candidate legality: border ring, head keep-out, apple, duplicates.
    always_comb begin
        on_border = (cx == 4'd0) || (cx == 4'd15) || (cy == 4'd0) || (cy == 4'd15);
        near_head = (abs_diff4(cx, head_q[7:4]) <= 4'd1) &&
                    (abs_diff4(cy, head_q[3:0]) <= 4'd1);
        accept    = !on_border && !near_head && (cand != apple_q) && (dup_hit == '0);
        count_inc = wall_count_q + 5'd1;
    end

    // Next-state and datapath updates for the generation sequence.
    always_comb begin
        state_d      = state_q;
        walls_d      = walls_q;
        wall_count_d = wall_count_q;
        target_d     = target_q;
        head_d       = head_q;
        apple_d      = apple_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gen_start) begin
                    head_d   = head_pos;
                    apple_d  = apple_pos;
                    target_d = (num_walls > MAX_W5) ? MAX_W5 : num_walls;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < MAX_WALLS; i++) walls_d[i] = EMPTY_POS;
                wall_count_d = 5'd0;
                state_d      = (target_q == 5'd0) ? ST_DONE : ST_GEN;
            end
            ST_GEN: begin
                if (accept) begin
                    for (int i = 0; i < MAX_WALLS; i++) begin
                        if (5'(i) == wall_count_q) walls_d[i] = cand;
                    end
                    wall_count_d = count_inc;
                    if (count_inc == target_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            walls_q      <= {MAX_WALLS{EMPTY_POS}};
            wall_count_q <= 5'd0;
            target_q     <= 5'd0;
            head_q       <= 8'h00;
            apple_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            walls_q      <= walls_d;
            wall_count_q <= wall_count_d;
            target_q     <= target_d;
            head_q       <= head_d;
            apple_q      <= apple_d;
        end
    end

    assign walls      = walls_q;
    assign wall_count = wall_count_q;
    assign busy       = (state_q == ST_CLEAR) || (state_q == ST_GEN);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_wall_generator.sv
// Directed testbench for wall_generator with a scoreboard of expected wall
// lists computed from an independent LFSR reference model.
module tb_wall_generator;

    logic             clk = 1'b0;
    logic             nrst;
    logic             gen_start;
    logic [4:0]       num_walls;
    logic [7:0]       head_pos;
    logic [7:0]       apple_pos;
    logic [24:0][7:0] walls;
    logic [4:0]       wall_count;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int               target;
        int               n_gen;
        logic [7:0]       head;
        logic [7:0]       apple;
        logic [24:0][7:0] w;
    } exp_t;

    exp_t sb[$];
    logic [7:0] m_lfsr;

    wall_generator dut (
        .clk        (clk),
        .nrst       (nrst),
        .gen_start  (gen_start),
        .num_walls  (num_walls),
        .head_pos   (head_pos),
        .apple_pos  (apple_pos),
        .walls      (walls),
        .wall_count (wall_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR tracking the DUT's free-running generator.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) m_lfsr <= 8'hA5;
        else       m_lfsr <= step(m_lfsr);
    end

    function automatic bit legal(input logic [7:0] c, input logic [7:0] h, input logic [7:0] a);
        int cx, cy, hx, hy, dx, dy;
        cx = int'(c[7:4]); cy = int'(c[3:0]);
        hx = int'(h[7:4]); hy = int'(h[3:0]);
        dx = (cx > hx) ? cx - hx : hx - cx;
        dy = (cy > hy) ? cy - hy : hy - cy;
        if (cx == 0 || cx == 15 || cy == 0 || cy == 15) return 1'b0;
        if (dx <= 1 && dy <= 1) return 1'b0;
        if (c == a) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start at the coming edge and push the expected result.
    task automatic start_gen(input int nw, input logic [7:0] h, input logic [7:0] a);
        exp_t e;
        logic [7:0] c;
        int cnt;
        bit dup;
        @(negedge clk);
        num_walls = 5'(nw);
        head_pos  = h;
        apple_pos = a;
        gen_start = 1'b1;
        e.target = (nw > 25) ? 25 : nw;
        e.head   = h;
        e.apple  = a;
        e.n_gen  = 0;
        for (int i = 0; i < 25; i++) e.w[i] = 8'h00;
        // Start edge consumes one step, CLEAR another; GEN sees the third value.
        c   = step(step(m_lfsr));
        cnt = 0;
        while (cnt < e.target && e.n_gen < 1000) begin
            e.n_gen++;
            dup = 1'b0;
            for (int i = 0; i < cnt; i++) if (e.w[i] == c) dup = 1'b1;
            if (legal(c, h, a) && !dup) begin
                e.w[cnt] = c;
                cnt++;
            end
            c = step(c);
        end
        sb.push_back(e);
    endtask

    // Wait for done within a bound, optionally re-pulsing gen_start while busy
    // (at cycle poke_k) and in the done cycle; then compare against the scoreboard.
    task automatic run_gen(input int poke_k, input bit poke_done);
        exp_t e;
        int k;
        bit seen, ok, dup;
        e = sb.pop_front();
        seen = 1'b0;
        k = 0;
        while (k < 300 && !seen) begin
            @(negedge clk);
            k++;
            gen_start = 1'b0;
            if (k == 1) chk("busy_after_start", 32'(busy), 32'd1);
            if (done) seen = 1'b1;
            else if (k == poke_k) begin
                gen_start = 1'b1;
                num_walls = 5'd20;
                head_pos  = 8'h22;
                apple_pos = 8'hBB;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("done_latency", 32'(k), 32'(2 + e.n_gen));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("wall_count", 32'(wall_count), 32'(e.target));
        for (int i = 0; i < 25; i++) chk($sformatf("walls[%0d]", i), 32'(walls[i]), 32'(e.w[i]));
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i < int'(wall_count)) begin
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (walls[j] == walls[i]) dup = 1'b1;
                if (dup || !legal(walls[i], e.head, e.apple)) ok = 1'b0;
            end else if (walls[i] != 8'h00) ok = 1'b0;
        end
        chk("invariants", 32'(ok), 32'd1);
        $display("gen target=%0d count=%0d latency=%0d head=%02h apple=%02h",
                 e.target, wall_count, k, e.head, e.apple);
        if (poke_done) gen_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gen_start = 1'b0;
            chk("post_done_quiet", 32'({done, busy}), 32'd0);
        end
        chk("hold_count", 32'(wall_count), 32'(e.target));
        chk("hold_walls0", 32'(walls[0]), 32'(e.w[0]));
    endtask

    initial begin
        int k;
        // Reset held with a start request asserted.
        nrst = 1'b0; gen_start = 1'b1; num_walls = 5'd5;
        head_pos = 8'h77; apple_pos = 8'h33;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 25; i++) chk($sformatf("rst_walls[%0d]", i), 32'(walls[i]), 32'd0);
        chk("rst_count", 32'(wall_count), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        gen_start = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'({busy, done}), 32'd0);

        // Zero walls: busy at T+1, done at T+2.
        start_gen(0, 8'h77, 8'h33);
        run_gen(0, 1'b0);

        // Five walls around a central head.
        start_gen(5, 8'h77, 8'h33);
        run_gen(0, 1'b0);

        // Over-range request clamps to 25.
        start_gen(31, 8'h5A, 8'hC4);
        run_gen(0, 1'b0);

        // Extra starts while busy and in the done cycle are ignored.
        start_gen(6, 8'h44, 8'h99);
        run_gen(3, 1'b1);

        // Reset ten cycles into GEN discards the run.
        start_gen(25, 8'h88, 8'h21);
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            gen_start = 1'b0;
        end
        chk("midrun_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("midrun_rst_count", 32'(wall_count), 32'd0);
        chk("midrun_rst_busy_done", 32'({busy, done}), 32'd0);
        chk("midrun_rst_walls", 32'(walls != '0), 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        start_gen(8, 8'h3C, 8'hE6);
        run_gen(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wall_generator.md
Name: wall_generator

Overview:
- Builds the wall-position list consumed by the wall-collision check: on a start pulse, fills up to MAX_WALLS unique legal cells using an LFSR.
- Candidates are rejected if they hit an existing wall, the snake head's 3x3 neighbourhood, the apple, or the border ring.
- Sits between game-control (start of level) and the collision / display stages.
- Position encoding is 8 bits, {x[3:0], y[3:0]}; the playfield interior is x,y in 1..14.

Parameters:
- MAX_WALLS, 25, number of wall slots in the output array.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.
- EMPTY_POS, 8'h00, value placed in unused slots. It is a border cell, so no legal head ever matches it.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- gen_start  in  1  single-cycle request to regenerate walls
- num_walls  in  5  requested wall count; values above MAX_WALLS are clamped to MAX_WALLS
- head_pos  in  8  snake head position, sampled on gen_start
- apple_pos  in  8  apple position, sampled on gen_start
- walls  out  [MAX_WALLS-1:0][7:0]  wall positions; unused slots = EMPTY_POS
- wall_count  out  5  number of valid slots filled
- busy  out  1  high from the cycle after an accepted gen_start until done
- done  out  1  one-cycle pulse when generation completes

Behaviour:
- Reset (async, nrst=0):
  - walls all EMPTY_POS, wall_count=0, busy=0, done=0.
  - state=IDLE, LFSR=LFSR_SEED, head/apple registers=0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255, never zero.
  - Free-running: advances every cycle in every state, so run-to-run variation comes from game timing.
- States: IDLE, CLEAR, GEN, DONE.
- IDLE:
  - gen_start=1 latches head_pos, apple_pos and the target min(num_walls, MAX_WALLS); goes to CLEAR.
  - Otherwise holds all outputs stable.
- CLEAR (1 cycle): walls all EMPTY_POS, wall_count=0, busy=1.
  - If target=0, go to DONE; else go to GEN.
- GEN, once per cycle: candidate c = current LFSR value, cx=c[7:4], cy=c[3:0]. Reject c if any of:
  - cx or cy is 0 or 15;
  - |cx-hx|<=1 and |cy-hy|<=1 (head keep-out, unsigned 4-bit difference computed without wrap);
  - c == apple;
  - c equals any walls[i] with i < wall_count (single-cycle parallel compare).
- On accept: walls[wall_count] <= c, wall_count++.
  - If wall_count+1 == target, go to DONE in the same cycle.
- GEN termination bound: at most 255 cycles, because one LFSR period visits every legal cell and at least 186 legal cells remain (196 minus at most 10 excluded).
- DONE (1 cycle): done=1, busy=0 in this cycle; then return to IDLE. walls and wall_count hold until the next accepted gen_start.
- Latency: gen_start at cycle T gives busy=1 from T+1.
  - target=0: done at T+2.
  - Otherwise: done at T+2+N_gen, where N_gen is the number of GEN cycles.
- gen_start while busy: ignored, with no restart and no queuing.
- gen_start in the DONE cycle: ignored.
- Changes to head_pos, apple_pos or num_walls during busy have no effect.
- Reset mid-generation: immediate return to reset values; partial walls are discarded.
- Invariants at done:
  - wall_count == target;
  - all walls[0..count-1] are unique and legal;
  - slots at index >= count hold EMPTY_POS.

Decomposition:
- Shared game package holds:
  - pos_t (8-bit position typedef);
  - GRID_MIN=1 and GRID_MAX=14;
  - MAX_WALLS=25;
  - EMPTY_POS;
  - the state enum wall_gen_state_t.
- Sub-module wall_lfsr (parameter SEED): outputs the 8-bit value, free-running, async active-low reset. The candidate legality check stays inline.

Test Plan:
- Reset: hold nrst=0 with gen_start=1 -> walls all 8'h00, wall_count=0, busy=0, done=0; no state change.
- num_walls=0, gen_start pulse at T -> busy at T+1, done at T+2, wall_count=0, walls all 8'h00.
- num_walls=5, head_pos=8'h77, apple_pos=8'h33 -> done within 257 cycles; 5 unique entries, none in x,y 6..8, none =8'h33, no x/y of 0 or 15, slots 5..24 =8'h00; values match the LFSR reference model.
- num_walls=31 -> clamps to 25; wall_count=25 at done; all 25 entries unique and legal.
- Extra gen_start: a second pulse 3 cycles after the first and one in the DONE cycle -> exactly one done pulse; walls match a single-start run.
- Reset mid-run: nrst low at 10 cycles into GEN -> outputs return to reset values at once; a new gen_start after release completes normally.
